// File: rtl/i2c_slave_responder.sv
// I2C target (slave) responder.
// Oversamples SCL/SDA with the system clock, decodes START/STOP, matches a
// 7-bit address, ACKs it, then either receives bytes (write) or serialises
// bytes fetched from the local side (read).
//
// Ports:
//   clk, reset_n    system clock, async active-low reset
//   scl_in, sda_in  raw bus lines (asynchronous to clk)
//   sda_oe          1 = pull SDA low (open drain)
//   ack_addr        high for the whole address-ACK bit on a match
//   rw_out          R/W bit of the current transfer
//   busy            matched address seen, cleared by STOP
//   rx_data/rx_valid  received byte and its one-clk strobe
//   tx_data/tx_req    byte to send; tx_data captured while tx_req is high
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       ack_addr,
  output logic       rw_out,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ACK_A     = 3'd2;
  localparam logic [2:0] S_WRITE     = 3'd3;
  localparam logic [2:0] S_ACK_W     = 3'd4;
  localparam logic [2:0] S_READ      = 3'd5;
  localparam logic [2:0] S_ACK_R     = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  // [0],[1] synchroniser, [2] previous synchronised value for edge detect
  logic [2:0] scl_sync_q, scl_sync_d;
  logic [2:0] sda_sync_q, sda_sync_d;

  // Bus events registered once; the FSM acts on them one clk later, which
  // puts sda_oe updates at pin edge + 4 clk.
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic start_q, start_d;
  logic stop_q, stop_d;
  logic sda_smp_q, sda_smp_d;

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic       ack_addr_q, ack_addr_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load;
  logic [7:0] shift_in;

  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], scl_in};
    sda_sync_d = {sda_sync_q[1:0], sda_in};
    rise_d     = scl_sync_q[1] & ~scl_sync_q[2];
    fall_d     = ~scl_sync_q[1] & scl_sync_q[2];
    start_d    = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[1] & sda_sync_q[2];
    stop_d     = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[1] & ~sda_sync_q[2];
    sda_smp_d  = sda_sync_q[1];
  end

  assign shift_in = {shift_q[6:0], sda_smp_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    ack_addr_d = ack_addr_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_load    = 1'b0;

    if (stop_q) begin
      // STOP has priority over any coincident SCL edge
      state_d    = S_IDLE;
      cnt_d      = 4'd0;
      busy_d     = 1'b0;
      ack_addr_d = 1'b0;
      sda_oe_d   = 1'b0;
    end else if (start_q) begin
      // START / repeated START: any partial byte is dropped
      state_d    = S_ADDR;
      cnt_d      = 4'd0;
      shift_d    = 8'h00;
      sda_oe_d   = 1'b0;
      ack_addr_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (rise_q) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              // general call (0x00) never matches
              if (shift_in[7:1] == SLAVE_ADDR && SLAVE_ADDR != 7'h00)
                state_d = S_ACK_A;
              else
                state_d = S_WAIT_STOP;
            end
          end
        end
        S_ACK_A: begin
          // ack_addr doubles as the "inside the ACK bit" marker
          if (fall_q) begin
            if (!ack_addr_q) begin
              sda_oe_d   = 1'b1;
              ack_addr_d = 1'b1;
              busy_d     = 1'b1;
              rw_d       = shift_q[0];
            end else begin
              ack_addr_d = 1'b0;
              cnt_d      = 4'd0;
              if (!rw_q) begin
                sda_oe_d = 1'b0;
                state_d  = S_WRITE;
              end else begin
                tx_load  = 1'b1;
                shift_d  = tx_data;
                sda_oe_d = ~tx_data[7];
                state_d  = S_READ;
              end
            end
          end
        end
        S_WRITE: begin
          if (rise_q) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d      = 4'd0;
              rx_data_d  = shift_in;
              rx_valid_d = 1'b1;
              state_d    = S_ACK_W;
            end
          end
        end
        S_ACK_W: begin
          // first fall starts the ACK bit, second fall ends it
          if (fall_q) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_WRITE;
            end
          end
        end
        S_READ: begin
          // cnt counts bits the master has clocked in
          if (rise_q) begin
            cnt_d = cnt_q + 4'd1;
          end else if (fall_q) begin
            if (cnt_q == 4'd8) begin
              cnt_d    = 4'd0;
              sda_oe_d = 1'b0;
              state_d  = S_ACK_R;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        S_ACK_R: begin
          // cnt == 1 records that the master ACKed
          if (rise_q) begin
            if (sda_smp_q) state_d = S_WAIT_STOP;
            else           cnt_d   = 4'd1;
          end else if (fall_q && cnt_q == 4'd1) begin
            cnt_d    = 4'd0;
            tx_load  = 1'b1;
            shift_d  = tx_data;
            sda_oe_d = ~tx_data[7];
            state_d  = S_READ;
          end
        end
        default: begin
          // IDLE and WAIT_STOP only react to START/STOP
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // lines idle high so reset release cannot fake an edge
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_smp_q  <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      sda_oe_q   <= 1'b0;
      ack_addr_q <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      sda_smp_q  <= sda_smp_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      ack_addr_q <= ack_addr_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign ack_addr = ack_addr_q;
  assign rw_out   = rw_q;
  assign busy     = busy_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  // tx_req is high in the very cycle whose closing edge loads tx_data
  assign tx_req   = tx_load;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a task-level I2C master drives the bus,
// monitors count strobes, and a transaction-level model supplies expectations.
module tb_i2c_slave_responder;
  localparam int Q = 5;              // clk cycles per quarter SCL period
  localparam logic [6:0] SA = 7'h50;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, ack_addr, rw_out, busy, rx_valid, tx_req;
  logic [7:0] rx_data, tx_data;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_responder #(.SLAVE_ADDR(SA)) dut (
    .clk(clk), .reset_n(reset_n), .scl_in(scl_m), .sda_in(sda_bus),
    .sda_oe(sda_oe), .ack_addr(ack_addr), .rw_out(rw_out), .busy(busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req)
  );

  always #5 clk = ~clk;

  // local-side byte source: advances once per tx_req pulse
  logic [7:0] tx_tab [0:255];
  int tx_idx = 0;
  assign tx_data = tx_tab[tx_idx[7:0]];
  always @(posedge clk) if (tx_req) tx_idx <= tx_idx + 1;

  // free-running monitors; tests work with deltas
  int rx_cnt = 0, tx_cnt = 0, ack_cyc = 0, oe_cyc = 0;
  logic [7:0] rx_q [$];
  always @(negedge clk) begin
    if (rx_valid) begin rx_cnt++; rx_q.push_back(rx_data); end
    if (tx_req)   tx_cnt++;
    if (ack_addr) ack_cyc++;
    if (sda_oe)   oe_cyc++;
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic qwait;
    repeat (Q) @(posedge clk);
    #2;
  endtask

  task automatic bit_x(input logic b, output logic r);
    sda_m = b; qwait;
    scl_m = 1'b1; qwait;
    r = sda_bus; qwait;
    scl_m = 1'b0; qwait;
  endtask

  task automatic do_start;
    sda_m = 1'b1; qwait;
    scl_m = 1'b1; qwait;
    sda_m = 1'b0; qwait;
    scl_m = 1'b0; qwait;
  endtask

  task automatic do_stop;
    sda_m = 1'b0; qwait;
    scl_m = 1'b1; qwait;
    sda_m = 1'b1; qwait; qwait;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ackd);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(b[i], r);
    bit_x(1'b1, r);
    ackd = ~r;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin bit_x(1'b1, r); b[i] = r; end
    bit_x(~mack, r);
  endtask

  // One complete transfer. For reads the master ACKs every byte but the last.
  task automatic xfer(input string tag, input logic [6:0] addr, input logic rw,
                      input int n, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic exp_ack);
    logic [7:0] d [3];
    logic a;
    logic [7:0] b;
    int rb, qb, tb0, ab, ob, ti;
    d[0] = d0; d[1] = d1; d[2] = d2;
    rb = rx_cnt; qb = rx_q.size(); tb0 = tx_cnt; ab = ack_cyc; ob = oe_cyc; ti = tx_idx;
    for (int k = 0; k < n; k++) tx_tab[(ti + k) % 256] = d[k];
    do_start;
    send_byte({addr, rw}, a);
    check({tag, " addr_ack"}, a, exp_ack);
    if (exp_ack) begin
      check({tag, " rw_out"}, rw_out, rw);
      check({tag, " busy"}, busy, 1);
    end
    if (exp_ack && rw) begin
      for (int k = 0; k < n; k++) begin
        recv_byte(k != n - 1, b);
        check($sformatf("%s rd%0d", tag, k), b, d[k]);
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        send_byte(d[k], a);
        check($sformatf("%s data_ack%0d", tag, k), a, exp_ack);
      end
    end
    do_stop;
    check({tag, " busy_after_stop"}, busy, 0);
    check({tag, " ack_addr_cycles"}, ack_cyc - ab, exp_ack ? 4 * Q : 0);
    check({tag, " rx_valid_count"}, rx_cnt - rb, (exp_ack && !rw) ? n : 0);
    check({tag, " tx_req_count"}, tx_cnt - tb0, (exp_ack && rw) ? n : 0);
    if (exp_ack && !rw)
      for (int k = 0; k < n; k++)
        check($sformatf("%s rx%0d", tag, k), rx_q[qb + k], d[k]);
    if (!exp_ack) check({tag, " sda_never_driven"}, oe_cyc - ob, 0);
  endtask

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    int         n;
    logic [7:0] d0, d1, d2;
    logic       exp_ack;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [7];
    logic a, r;
    logic [7:0] b;
    int rb, qb, ti;

    vt[0] = '{7'h50, 1'b0, 1, 8'hA5, 8'h00, 8'h00, 1'b1};
    vt[1] = '{7'h51, 1'b0, 1, 8'h3C, 8'h00, 8'h00, 1'b0};
    vt[2] = '{7'h50, 1'b1, 2, 8'h96, 8'h0F, 8'h00, 1'b1};
    vt[3] = '{7'h00, 1'b0, 1, 8'h55, 8'h00, 8'h00, 1'b0};
    vt[4] = '{7'h50, 1'b0, 3, 8'h00, 8'hFF, 8'h81, 1'b1};
    vt[5] = '{7'h50, 1'b1, 1, 8'h5A, 8'h00, 8'h00, 1'b1};
    vt[6] = '{7'h28, 1'b1, 1, 8'h77, 8'h00, 8'h00, 1'b0};

    // reset values
    repeat (4) @(posedge clk); #2;
    check("rst sda_oe", sda_oe, 0);
    check("rst ack_addr", ack_addr, 0);
    check("rst rw_out", rw_out, 0);
    check("rst busy", busy, 0);
    check("rst rx_data", rx_data, 8'h00);
    check("rst rx_valid", rx_valid, 0);
    check("rst tx_req", tx_req, 0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk); #2;

    foreach (vt[i])
      xfer($sformatf("vec%0d", i), vt[i].addr, vt[i].rw, vt[i].n,
           vt[i].d0, vt[i].d1, vt[i].d2, vt[i].exp_ack);

    // write 0x11 then repeated START into a read
    rb = rx_cnt; qb = rx_q.size(); ti = tx_idx;
    tx_tab[ti % 256] = 8'hC3;
    do_start;
    send_byte({SA, 1'b0}, a);  check("rs addr_w_ack", a, 1);
    send_byte(8'h11, a);       check("rs data_ack", a, 1);
    do_start;
    send_byte({SA, 1'b1}, a);  check("rs addr_r_ack", a, 1);
    check("rs rw_out", rw_out, 1);
    recv_byte(1'b0, b);        check("rs rd", b, 8'hC3);
    do_stop;
    check("rs rx_valid_count", rx_cnt - rb, 1);
    check("rs rx_byte", rx_q[qb], 8'h11);

    // STOP after 4 data bits: partial byte dropped
    rb = rx_cnt;
    do_start;
    send_byte({SA, 1'b0}, a);  check("part addr_ack", a, 1);
    bit_x(1'b1, r); bit_x(1'b0, r); bit_x(1'b1, r); bit_x(1'b0, r);
    do_stop;
    check("part rx_valid_count", rx_cnt - rb, 0);
    check("part rx_data_kept", rx_data, 8'h11);
    check("part busy", busy, 0);

    // reset asserted inside the address ACK bit
    do_start;
    for (int i = 7; i >= 0; i--) bit_x(((8'hA0 >> i) & 8'h01) != 0, r);
    sda_m = 1'b1; qwait;
    check("rstack sda_oe_before", sda_oe, 1);
    check("rstack ack_addr_before", ack_addr, 1);
    reset_n = 1'b0; #1;
    check("rstack sda_oe", sda_oe, 0);
    check("rstack ack_addr", ack_addr, 0);
    check("rstack busy", busy, 0);
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (10) @(posedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk); #2;
    xfer("post_rst", SA, 1'b0, 1, 8'h42, 8'h00, 8'h00, 1'b1);

    // randomized transfers against the transaction model
    for (int t = 0; t < 16; t++) begin
      logic [6:0] ad;
      logic       rw;
      int         n;
      ad = ($urandom % 2) ? SA : 7'($urandom_range(0, 127));
      rw = 1'($urandom % 2);
      n  = $urandom_range(1, 3);
      xfer($sformatf("rnd%0d", t), ad, rw, n, 8'($urandom), 8'($urandom),
           8'($urandom), ad == SA);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
# i2c_slave_responder

Bus-side target that sits directly downstream of the I2C master FSM: it consumes the master's SCL/SDA lines, decodes START/STOP, matches a 7-bit address, and acknowledges. For writes it delivers received bytes to the local register side; for reads it serialises bytes supplied by that side. It also produces the address-acknowledge indication that feeds the master's ACK input. SCL and SDA are oversampled by a faster system clock.

## Interface

- SLAVE_ADDR, 7'h50, 7-bit address this target responds to
- clk  in  1  system clock; must be at least 8x the SCL frequency
- reset_n  in  1  asynchronous, active-low reset
- scl_in  in  1  SCL line from master, asynchronous to clk
- sda_in  in  1  SDA line as seen on the bus, asynchronous to clk
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release
- ack_addr  out  1  high for the whole address-ACK bit when the address matched; feeds the master's ACK input
- rw_out  out  1  R/W bit of the current transfer, valid from address ACK until STOP
- busy  out  1  high from a matched address until STOP
- rx_data  out  8  last byte written by the master
- rx_valid  out  1  one-clk pulse when rx_data is updated
- tx_data  in  8  byte to return on a read; sampled when tx_req is high
- tx_req  out  1  one-clk pulse; tx_data is captured in the same cycle

## Operation

- Synchronisation: scl_in and sda_in each pass through 2 flops, then a third flop for edge detection. Bus events are acted on 3 clk after the pin change.
- START is SDA falling while SCL is high. It is honoured from any state, including a repeated START: state goes to ADDR, bit counter is cleared, sda_oe is released.
- STOP is SDA rising while SCL is high. From any state it goes to IDLE, and busy, ack_addr and sda_oe are cleared.
- Data is sampled on the synchronised SCL rising edge. sda_oe changes only on the synchronised SCL falling edge, at detect + 1 clk. Bytes are MSB first.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits, 7 address bits then R/W. After the 8th rising edge: on match go to ACK_A; on mismatch go to WAIT_STOP with SDA never driven.
  - ACK_A: on the falling edge entering the ACK bit, set sda_oe=1, ack_addr=1, busy=1 and latch rw_out. On the next falling edge, clear ack_addr. If rw=0, release SDA and go to WRITE. If rw=1, pulse tx_req, load the shifter from tx_data, drive its MSB and go to READ.
  - WRITE: shift in 8 bits. After the 8th rising edge, set rx_data to the byte and pulse rx_valid in the same clk. Then go to ACK_W.
  - ACK_W: drive ACK (sda_oe=1) for one SCL period, release on the next falling edge, return to WRITE. Every written byte is ACKed.
  - READ: on each falling edge, present the next bit; sda_oe = ~bit. After the 8th bit's falling edge period, release SDA and go to ACK_R.
  - ACK_R: sample the master's ACK on the rising edge.
    - SDA low: on the next falling edge pulse tx_req, reload the shifter, drive the new MSB and return to READ.
    - SDA high (NACK): go to WAIT_STOP.
  - WAIT_STOP: SDA released; ignore everything except START/STOP.
- General-call address (0x00) and 10-bit addressing are not supported; both are treated as a mismatch.

## Timing

- Reset values (async, immediate):
  - state IDLE, sda_oe 0, ack_addr 0, rw_out 0, busy 0
  - rx_data 8'h00, rx_valid 0, tx_req 0, shift/count 0
- Event latency: pin edge to internal edge detect is 3 clk. sda_oe update is 4 clk after the SCL pin falls.
- rx_valid is exactly 1 clk per received byte. tx_req is exactly 1 clk per transmitted byte, and tx_data must be stable in that cycle.
- START/STOP seen mid-byte: the partial byte is discarded, with no rx_valid.
- If STOP and a falling edge are detected in the same clk, STOP wins.
- If START and a rising edge are detected in the same clk, START wins.
- Reset asserted mid-ACK releases SDA in the same cycle; no state survives.

## Test plan

- START, addr 0x50 W, byte 0xA5, STOP:
  - ACK on the address bit; ack_addr high for one SCL period.
  - rx_data=0xA5 with a single rx_valid pulse; data byte ACKed.
  - busy drops after STOP.
- START, addr 0x51 W, byte 0x3C:
  - sda_oe stays 0 throughout; no ack_addr, no rx_valid.
  - state is WAIT_STOP until STOP.
- START, addr 0x50 R, tx_data 0x96 then 0x0F, master ACK then NACK:
  - bus bits 10010110, then 00001111.
  - two tx_req pulses, then SDA released and WAIT_STOP.
- Write 0x50 W with 0x11, then repeated START 0x50 R:
  - second address is ACKed and rw_out=1 after the ACK.
  - exactly one rx_valid pulse.
- STOP after 4 data bits of a write: returns to IDLE, no rx_valid, rx_data keeps its previous value.
- reset_n low during the address ACK bit: sda_oe and ack_addr drop to 0 immediately. After release, a fresh 0x50 W transfer completes normally.
